// File: rtl/rx_phy_pkg.sv
// rx_phy_pkg: shared comma character, lock default and aligner state encoding
package rx_phy_pkg;
  localparam logic [7:0] COMMA_CHAR = 8'hBC;
  localparam int LOCK_COUNT_DEF = 4;
  typedef enum logic [1:0] {SEARCH, COUNT, ACTIVE} state_t;
endpackage

// File: rtl/serial_aligner_if.sv
// serial_aligner_if: lane bundle (data_input in; data_output, byte_strobe, valid_out, active_output, BC_contador out)
interface serial_aligner_if;
  logic data_input;
  logic [7:0] data_output;
  logic byte_strobe;
  logic valid_out;
  logic active_output;
  logic [2:0] BC_contador;
  modport master (output data_input, input data_output, byte_strobe, valid_out, active_output, BC_contador);
  modport slave (input data_input, output data_output, byte_strobe, valid_out, active_output, BC_contador);
endinterface

// File: rtl/serial_aligner.sv
// serial_aligner: comma-hunting byte aligner; clk_32f/reset_L plain ports, lane bits and aligned byte outputs on lane
module serial_aligner
  import rx_phy_pkg::*;
#(
  parameter logic [7:0] COMMA = COMMA_CHAR,
  parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
  input logic clk_32f,
  input logic reset_L,
  serial_aligner_if.slave lane
);
  localparam logic [2:0] LOCK = 3'(LOCK_COUNT);
  state_t state, state_d;
  logic [6:0] sr;
  logic [7:0] cand, dout, dout_d;
  logic [2:0] cnt, cnt_d, bc, bc_d;
  logic strobe, strobe_d, valid, valid_d, boundary, is_comma;
  assign cand = {sr, lane.data_input};
  assign boundary = cnt == 3'd7;
  assign is_comma = cand == COMMA;
  always_comb begin
    state_d = state;
    cnt_d = cnt + 3'd1;
    bc_d = bc;
    dout_d = dout;
    strobe_d = 1'b0;
    valid_d = 1'b0;
    case (state)
      SEARCH: if (is_comma) begin
        cnt_d = '0;
        bc_d = 3'd1;
        state_d = (LOCK == 3'd1) ? ACTIVE : COUNT;
      end
      COUNT: if (boundary) begin
        bc_d = is_comma ? bc + 3'd1 : '0;
        state_d = !is_comma ? SEARCH : (bc + 3'd1 == LOCK) ? ACTIVE : COUNT;
      end
      ACTIVE: if (boundary) begin
        dout_d = cand;
        strobe_d = 1'b1;
        valid_d = !is_comma;
      end
      default: state_d = SEARCH;
    endcase
  end
  always_ff @(posedge clk_32f or negedge reset_L) begin
    if (!reset_L) begin
      state <= SEARCH;
      sr <= '0;
      cnt <= '0;
      bc <= '0;
      dout <= '0;
      strobe <= 1'b0;
      valid <= 1'b0;
    end else begin
      state <= state_d;
      sr <= cand[6:0];
      cnt <= cnt_d;
      bc <= bc_d;
      dout <= dout_d;
      strobe <= strobe_d;
      valid <= valid_d;
    end
  end
  assign lane.data_output = dout;
  assign lane.byte_strobe = strobe;
  assign lane.valid_out = valid;
  assign lane.active_output = state == ACTIVE;
  assign lane.BC_contador = bc;
endmodule
